// File: rtl/ppb_initiator.sv
// ppb_initiator: probe-bus master that frames header, ID check, input shift-out, output capture and commit
module ppb_initiator #(
  parameter int          INPUT_BLOCKS  = 20,
  parameter int          OUTPUT_BLOCKS = 40,
  parameter int          CLK_DIV       = 4,
  parameter logic [22:0] PROJECT_ID    = 23'h31c748
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [3*INPUT_BLOCKS-1:0]  in_data,
  output logic                       busy,
  output logic                       done,
  output logic                       id_ok,
  output logic [3*OUTPUT_BLOCKS-1:0] out_data,
  output logic                       pmod_bus_clk,
  output logic                       pmod_bus_control,
  output logic [2:0]                 pmod_bus_poti,
  input  logic [2:0]                 pmod_bus_pito
);
  localparam int M1   = INPUT_BLOCKS > 8 ? INPUT_BLOCKS : 8;
  localparam int PMAX = OUTPUT_BLOCKS > M1 ? OUTPUT_BLOCKS : M1;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int HW   = $clog2(CLK_DIV) + 1;
  typedef enum logic [2:0] {IDLE, HDR, ID, TX, RX, END, FIN, ABORT} state_t;
  state_t                     state;
  logic [HW-1:0]              h;
  logic [PW-1:0]              p;
  logic [3*INPUT_BLOCKS-1:0]  sr;
  logic [3*OUTPUT_BLOCKS-1:0] stage;
  logic [23:0]                id_reg;
  logic [2:0]                 sync1, sync2;
  logic                       last_low, last_half, p_last, id_match;
  always_comb begin
    last_low  = h == HW'(CLK_DIV - 1);
    last_half = h == HW'(2 * CLK_DIV - 1);
    p_last    = state == ID ? p == PW'(7) :
                state == TX ? p == PW'(INPUT_BLOCKS - 1) :
                state == RX ? p == PW'(OUTPUT_BLOCKS - 1) : 1'b1;
    id_match  = id_reg == {1'b0, PROJECT_ID};
  end
  // h spans a whole bus period: low half first, high half second
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      h                <= '0;
      p                <= '0;
      sr               <= '0;
      stage            <= '0;
      id_reg           <= '0;
      sync1            <= '0;
      sync2            <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      id_ok            <= 1'b0;
      out_data         <= '0;
      pmod_bus_clk     <= 1'b0;
      pmod_bus_control <= 1'b0;
      pmod_bus_poti    <= '0;
    end else begin
      sync1 <= pmod_bus_pito;
      sync2 <= sync1;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sr               <= in_data;
          busy             <= 1'b1;
          state            <= HDR;
          h                <= '0;
          p                <= '0;
          pmod_bus_control <= 1'b1;
          pmod_bus_poti    <= 3'b101;
        end
        FIN, ABORT: state <= IDLE;
        default: begin
          h            <= last_half ? '0 : h + 1'b1;
          pmod_bus_clk <= last_low ? 1'b1 : last_half ? 1'b0 : pmod_bus_clk;
          if (last_low && state == ID) id_reg <= {id_reg[20:0], sync2};
          if (last_low && state == RX) stage <= {sync2, stage[3*OUTPUT_BLOCKS-1:3]};
          if (last_half) begin
            p <= p_last ? '0 : p + 1'b1;
            case (state)
              HDR: begin
                state            <= ID;
                pmod_bus_control <= 1'b0;
                pmod_bus_poti    <= '0;
              end
              ID: if (p_last) begin
                if (id_match) begin
                  state         <= TX;
                  pmod_bus_poti <= sr[2:0];
                  sr            <= sr >> 3;
                end else begin
                  state <= ABORT;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  id_ok <= 1'b0;
                end
              end
              TX: begin
                pmod_bus_poti <= p_last ? 3'b000 : sr[2:0];
                sr            <= sr >> 3;
                if (p_last) state <= RX;
              end
              RX: if (p_last) begin
                state            <= END;
                pmod_bus_control <= 1'b1;
                pmod_bus_poti    <= 3'b010;
              end
              END: begin
                state            <= FIN;
                pmod_bus_control <= 1'b0;
                pmod_bus_poti    <= '0;
                done             <= 1'b1;
                busy             <= 1'b0;
                id_ok            <= 1'b1;
                out_data         <= stage;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ppb_initiator.sv
// tb_ppb_initiator: directed checks of framing, ID abort, start filtering and reset on two bus-clock ratios
module tb_ppb_initiator;
  localparam int IB = 20, OB = 40;
  logic clk = 0, rst = 0, start0 = 0, start1 = 0;
  logic [3*IB-1:0] in_data = '0;
  logic [3*OB-1:0] out0, out1, exp_out = '0;
  logic busy0, done0, idok0, bclk0, ctl0, busy1, done1, idok1, bclk1, ctl1;
  logic [2:0] poti0, poti1, pito0 = '0, pito1 = '0;
  logic [23:0] id0 = 24'h31c748, id1 = 24'h31c748;
  logic [2:0] rp0 [80];
  logic rc0 [80];
  int r0 = 0, r1 = 0, cyc = 0, tests = 0, fails = 0;
  bit pb0, pb1, pbusy0, pbusy1;

  ppb_initiator dut0 (.clk(clk), .rst(rst), .start(start0), .in_data(in_data), .busy(busy0),
    .done(done0), .id_ok(idok0), .out_data(out0), .pmod_bus_clk(bclk0),
    .pmod_bus_control(ctl0), .pmod_bus_poti(poti0), .pmod_bus_pito(pito0));
  ppb_initiator #(.CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .start(start1), .in_data(in_data),
    .busy(busy1), .done(done1), .id_ok(idok1), .out_data(out1), .pmod_bus_clk(bclk1),
    .pmod_bus_control(ctl1), .pmod_bus_poti(poti1), .pmod_bus_pito(pito1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] tgt(int q, logic [23:0] id);
    if (q >= 1 && q <= 8) return id[3*(8-q) +: 3];
    if (q >= 9 + IB && q < 9 + IB + OB) return 3'((q - 9 - IB) % 8);
    return 3'b000;
  endfunction

  // target for the slow instance: at the rise of period r it presents data for period r+1
  always @(negedge clk) begin
    if (busy0 && !pbusy0) r0 = 0;
    if (busy0 && bclk0 && !pb0) begin
      if (r0 < 80) begin
        rp0[r0] = poti0;
        rc0[r0] = ctl0;
      end
      r0++;
      pito0 = tgt(r0, id0);
    end
    pb0 = bclk0;
    pbusy0 = busy0;
  end

  // the fast instance samples two clk after its synchronizer, so the target runs two periods ahead
  always @(negedge clk) begin
    if (!busy1) pito1 = tgt(1, id1);
    if (busy1 && !pbusy1) r1 = 0;
    if (busy1 && bclk1 && !pb1) begin
      r1++;
      pito1 = tgt(r1 + 1, id1);
    end
    pb1 = bclk1;
    pbusy1 = busy1;
  end

  task automatic wait_done0(output int lat);
    int b;
    b = busy0 ? cyc : -1;
    lat = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (busy0 && b < 0) b = cyc;
      if (done0) begin
        lat = (b < 0) ? -1 : cyc - b;
        break;
      end
    end
  endtask

  task automatic run0(output int lat);
    @(negedge clk); #1 start0 = 1;
    @(negedge clk); #1 start0 = 0;
    wait_done0(lat);
  endtask

  task automatic run1(output int lat);
    int b;
    @(negedge clk); #1 start1 = 1;
    @(negedge clk); #1 start1 = 0;
    b = busy1 ? cyc : -1;
    lat = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (busy1 && b < 0) b = cyc;
      if (done1) begin
        lat = (b < 0) ? -1 : cyc - b;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int bad_clk, bad_out;
    rst = 0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({busy0, done0, idok0, bclk0, ctl0, poti0, out0} !== '0) begin
      fails++; $display("FAIL reset_dut0 got %h want 0", {busy0, done0, idok0, bclk0, ctl0, poti0, out0});
    end
    tests++;
    if ({busy1, done1, idok1, bclk1, ctl1, poti1, out1} !== '0) begin
      fails++; $display("FAIL reset_dut1 got %h want 0", {busy1, done1, idok1, bclk1, ctl1, poti1, out1});
    end
    rst = 1;
    bad_clk = 0;
    bad_out = 0;
    repeat (1000) begin
      @(negedge clk); #1;
      if (bclk0 !== 1'b0 || bclk1 !== 1'b0) bad_clk++;
      if ({busy0, done0, idok0, ctl0, poti0, out0, busy1, done1, idok1, ctl1, poti1, out1} !== '0) bad_out++;
    end
    tests++;
    if (bad_clk !== 0) begin fails++; $display("FAIL idle_bus_clk got %0d active cycles want 0", bad_clk); end
    tests++;
    if (bad_out !== 0) begin fails++; $display("FAIL idle_outputs got %0d nonzero cycles want 0", bad_out); end
  endtask

  task automatic test_nominal;
    int lat, errs;
    logic ec;
    logic [2:0] ep;
    id0 = 24'h31c748;
    run0(lat);
    tests++;
    if (lat !== 560) begin fails++; $display("FAIL nominal_latency got %0d want 560", lat); end
    tests++;
    if (busy0 !== 1'b0) begin fails++; $display("FAIL nominal_busy_at_done got %b want 0", busy0); end
    tests++;
    if (idok0 !== 1'b1) begin fails++; $display("FAIL nominal_id_ok got %b want 1", idok0); end
    tests++;
    if (out0 !== exp_out) begin fails++; $display("FAIL nominal_out_data got %h want %h", out0, exp_out); end
    tests++;
    if (r0 !== 70) begin fails++; $display("FAIL nominal_periods got %0d want 70", r0); end
    errs = 0;
    for (int p = 0; p < 70; p++) begin
      ec = (p == 0 || p == 69);
      ep = p == 0 ? 3'b101 : p == 69 ? 3'b010 : (p >= 9 && p < 29) ? 3'((p - 6) % 8) : 3'b000;
      if (rc0[p] !== ec || rp0[p] !== ep) begin
        if (errs == 0) $display("FAIL nominal_bus_seq period %0d got ctl=%b poti=%b want ctl=%b poti=%b", p, rc0[p], rp0[p], ec, ep);
        errs++;
      end
    end
    tests++;
    if (errs !== 0) begin fails++; $display("FAIL nominal_bus_seq_total got %0d bad periods want 0", errs); end
    @(negedge clk); #1;
    tests++;
    if (done0 !== 1'b0) begin fails++; $display("FAIL nominal_done_width got %b want 0", done0); end
  endtask

  task automatic test_id_abort(input logic [23:0] id);
    int lat, errs;
    id0 = id;
    run0(lat);
    tests++;
    if (lat !== 72) begin fails++; $display("FAIL abort_%h_latency got %0d want 72", id, lat); end
    tests++;
    if (idok0 !== 1'b0) begin fails++; $display("FAIL abort_%h_id_ok got %b want 0", id, idok0); end
    tests++;
    if (out0 !== exp_out) begin fails++; $display("FAIL abort_%h_out_data got %h want %h", id, out0, exp_out); end
    tests++;
    if (r0 !== 9) begin fails++; $display("FAIL abort_%h_periods got %0d want 9", id, r0); end
    errs = 0;
    for (int p = 1; p < 9; p++) if (rc0[p] !== 1'b0 || rp0[p] !== 3'b000) errs++;
    tests++;
    if (errs !== 0) begin fails++; $display("FAIL abort_%h_id_bus got %0d bad periods want 0", id, errs); end
  endtask

  task automatic test_start_busy;
    int nd;
    id0 = 24'h31c748;
    @(negedge clk); #1 start0 = 1;
    @(negedge clk); #1 start0 = 0;
    nd = 0;
    for (int i = 0; i < 1300; i++) begin
      @(negedge clk); #1;
      start0 = (i == 100);
      if (done0) nd++;
    end
    start0 = 0;
    tests++;
    if (nd !== 1) begin fails++; $display("FAIL start_busy_done_count got %0d want 1", nd); end
    tests++;
    if (idok0 !== 1'b1) begin fails++; $display("FAIL start_busy_id_ok got %b want 1", idok0); end
    tests++;
    if (busy0 !== 1'b0) begin fails++; $display("FAIL start_busy_idle got %b want 0", busy0); end
  endtask

  task automatic test_back_to_back;
    int lat, nb;
    id0 = 24'h31c748;
    run0(lat);
    tests++;
    if (lat !== 560) begin fails++; $display("FAIL b2b_first_latency got %0d want 560", lat); end
    start0 = 1;
    @(negedge clk); #1 start0 = 0;
    nb = 0;
    repeat (20) begin
      if (busy0) nb++;
      @(negedge clk); #1;
    end
    tests++;
    if (nb !== 0) begin fails++; $display("FAIL b2b_start_in_fin got %0d busy cycles want 0", nb); end
    id0 = 24'h31c749;
    run0(lat);
    tests++;
    if (lat !== 72) begin fails++; $display("FAIL b2b_abort_latency got %0d want 72", lat); end
    @(negedge clk); #1 start0 = 1;
    @(negedge clk); #1 start0 = 0;
    tests++;
    if (busy0 !== 1'b1) begin fails++; $display("FAIL b2b_start_after_done got busy=%b want 1", busy0); end
    wait_done0(lat);
    tests++;
    if (lat !== 72) begin fails++; $display("FAIL b2b_second_latency got %0d want 72", lat); end
  endtask

  task automatic test_reset_mid;
    int lat;
    bit found;
    id1 = 24'h31c748;
    run1(lat);
    tests++;
    if (lat !== 140) begin fails++; $display("FAIL fast_latency got %0d want 140", lat); end
    tests++;
    if (idok1 !== 1'b1 || out1 !== exp_out) begin
      fails++; $display("FAIL fast_result got id_ok=%b out=%h want 1 %h", idok1, out1, exp_out);
    end
    @(negedge clk); #1 start1 = 1;
    @(negedge clk); #1 start1 = 0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #1;
      found = r1 >= 31;
    end
    tests++;
    if (!found) begin fails++; $display("FAIL mid_reach_period30 got r=%0d want >=31", r1); end
    rst = 0;
    #1;
    tests++;
    if ({busy1, done1, idok1, bclk1, ctl1, poti1} !== '0) begin
      fails++; $display("FAIL mid_reset_ctrl got %b want 0", {busy1, done1, idok1, bclk1, ctl1, poti1});
    end
    tests++;
    if (out1 !== '0) begin fails++; $display("FAIL mid_reset_out_data got %h want 0", out1); end
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({busy1, done1, idok1, bclk1, ctl1, poti1, out1} !== '0) begin
      fails++; $display("FAIL mid_reset_hold got %h want 0", {busy1, done1, idok1, bclk1, ctl1, poti1, out1});
    end
    rst = 1;
    run1(lat);
    tests++;
    if (lat !== 140) begin fails++; $display("FAIL restart_latency got %0d want 140", lat); end
    tests++;
    if (idok1 !== 1'b1) begin fails++; $display("FAIL restart_id_ok got %b want 1", idok1); end
    tests++;
    if (out1 !== exp_out) begin fails++; $display("FAIL restart_out_data got %h want %h", out1, exp_out); end
  endtask

  initial begin
    for (int k = 0; k < IB; k++) in_data[3*k +: 3] = 3'((k + 3) % 8);
    for (int k = 0; k < OB; k++) exp_out[3*k +: 3] = 3'(k % 8);
    test_reset;
    test_nominal;
    test_id_abort(24'h31c749);
    test_id_abort(24'hb1c748);
    test_start_busy;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ppb_initiator.md
Name: ppb_initiator

Overview:
- Host-side master for the PMOD probe bus; it is the opposite end of the FPGA-side probe PHY.
- Generates the bus clock and frames each exchange.
- Reads back and checks the target's project ID, shifts input blocks out to the target, and captures output blocks from it.
- Used in the bench-side probe adapter and in loopback regression against the PHY.

Parameters:
- INPUT_BLOCKS, 20, number of 3-bit blocks sent to the target per frame.
- OUTPUT_BLOCKS, 40, number of 3-bit blocks read from the target per frame.
- CLK_DIV, 4, clk cycles per bus-clock half period; must be >= 1.
- PROJECT_ID, 23'h31c748, expected target ID.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to run a frame.
- in_data  input  3*INPUT_BLOCKS  blocks to send; block k = in_data[3k+2:3k].
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at frame end.
- id_ok  output  1  result of the last frame's ID check.
- out_data  output  3*OUTPUT_BLOCKS  captured blocks; block k = out_data[3k+2:3k].
- pmod_bus_clk  output  1  bus clock.
- pmod_bus_control  output  1  frame control strobe.
- pmod_bus_poti  output  3  data from initiator to target.
- pmod_bus_pito  input  3  data from target to initiator; double-flop synchronized internally.

Behaviour:
- Reset (rst=0, asynchronous):
  - busy, done, id_ok, pmod_bus_clk, pmod_bus_control are 0.
  - pmod_bus_poti = 0 and out_data = 0.
  - State goes to IDLE.
- Bus period:
  - Each period is 2*CLK_DIV clk cycles: a low half then a high half of pmod_bus_clk.
  - control and poti change only on the first clk cycle of the low half.
  - pito (post-synchronizer) is sampled on the last clk cycle of the low half.
- Start:
  - start is sampled in IDLE only; start during busy is ignored.
  - On acceptance, in_data is latched into a shift register.
  - busy rises the next cycle, and the first period begins that same cycle.
- States, one bus period per step unless noted:
  - IDLE: bus_clk held low; control=0; poti=0.
  - HDR, 1 period: control=1, poti=3'b101.
  - ID, 8 periods: control=0, poti=0. Capture pito MSB-first into a 24-bit register. ID OK when reg[23]==0 and reg[22:0]==PROJECT_ID.
    - Mismatch: go to ABORT.
    - Match: go to TX.
  - TX, INPUT_BLOCKS periods: poti = block 0, 1, 2, … in order; control=0.
  - RX, OUTPUT_BLOCKS periods: poti=0. Capture pito of period k into staging block k.
  - END, 1 period: control=1, poti=3'b010 (commit).
  - FIN, 1 clk:
    - out_data <= staging, updated atomically.
    - id_ok <= 1, done=1, busy <= 0.
    - Return to IDLE.
  - ABORT: control=0 and poti=0 for the rest of the current period, then 1 clk with done=1, id_ok <= 0, busy <= 0. out_data is unchanged.
- Latency:
  - A full frame is 1+8+INPUT_BLOCKS+OUTPUT_BLOCKS+1 periods.
  - With defaults: 70 periods = 560 clk.
  - done is asserted 560 clk after busy rises.
  - Abort (ID mismatch): done is asserted 9*2*CLK_DIV = 72 clk after busy rises.
- Counters:
  - Period counter is $clog2(max(8, INPUT_BLOCKS, OUTPUT_BLOCKS)+1) bits.
  - Half-period counter is $clog2(CLK_DIV)+1 bits.
  - Neither counter wraps within a state; each resets on state entry.
- Corner cases:
  - start asserted in the FIN or ABORT cycle: ignored.
  - start asserted the cycle after done: accepted.
  - Reset mid-frame: returns to the reset values immediately, including out_data = 0. A partial frame never updates out_data.
  - done and busy are never both 1.
  - id_ok holds its value until the next done.

Test Plan:
- Reset idle:
  - Stimulus: hold rst=0, release; no start.
  - Required: pmod_bus_clk stays 0 and all outputs stay 0 for 1000 clk.
- Nominal frame:
  - Stimulus: target model returns ID 24'h31c748, then pito = k mod 8 for RX block k. in_data blocks k = (k+3) mod 8.
  - Required: poti order 101, ID zeros, 3,4,5…, RX zeros, 010.
  - Required: out_data block k = k mod 8; id_ok=1; done 560 clk after busy.
- ID mismatch:
  - Stimulus: target returns 24'h31c749.
  - Required: done 72 clk after busy; id_ok=0; out_data unchanged from the previous frame; control never reaches the END strobe.
- ID bit 23 set:
  - Stimulus: target returns 24'hB1c748.
  - Required: abort, with the same response as the mismatch case.
- Start while busy:
  - Stimulus: pulse start at cycle 100 of a frame.
  - Required: no second frame; exactly one done.
- Reset mid-RX, then restart:
  - Stimulus: rst=0 at period 30; release; start again.
  - Required: outputs are at reset values while rst=0. The restarted frame completes normally with CLK_DIV=1 (140 clk).
